// File: rtl/fixedpoint_addsub_arbiter_if.sv
// Handshake bundle between NREQ requesting lanes, the shared add/sub arbiter and its result consumer.
// The slave modport is the arbiter's view; the master modport is the lanes-plus-consumer view.
interface fixedpoint_addsub_arbiter_if #(
  parameter int NREQ = 4,
  parameter int WII  = 8,
  parameter int WIF  = 8,
  parameter int WOI  = 8,
  parameter int WOF  = 8,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ*(WII+WIF)-1:0] req_ina;
  logic [NREQ*(WII+WIF)-1:0] req_inb;
  logic [NREQ-1:0]           req_sub;
  logic                      out_valid;
  logic                      out_ready;
  logic [WOI+WOF-1:0]        out;
  logic [IDW-1:0]            out_id;
  logic                      out_upflow;
  logic                      out_downflow;

  modport master (
    output req_valid, req_ina, req_inb, req_sub, out_ready,
    input  req_ready, out_valid, out, out_id, out_upflow, out_downflow
  );

  modport slave (
    input  req_valid, req_ina, req_inb, req_sub, out_ready,
    output req_ready, out_valid, out, out_id, out_upflow, out_downflow
  );
endinterface

// File: rtl/fixedpoint_addsub_arbiter.sv
// Round-robin shared fixed-point add/subtract unit with a single registered result slot.
// Exact sum is formed wide, fraction-reduced (round or floor), range-checked, then saturated or wrapped.
module fixedpoint_addsub_arbiter #(
  parameter int NREQ  = 4,
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROOF  = 1,
  parameter int ROUND = 1,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  fixedpoint_addsub_arbiter_if.slave  bus
);
  localparam int WI  = WII + WIF;
  localparam int WO  = WOI + WOF;
  localparam int WX  = WI + WO + 4;
  localparam int SHR = (WIF > WOF) ? WIF - WOF : 0;
  localparam int SHL = (WOF > WIF) ? WOF - WIF : 0;
  localparam int RSH = (SHR > 0) ? SHR - 1 : 0;
  localparam logic signed [WX-1:0] ONE  = 1;
  localparam logic signed [WX-1:0] VMAX = (ONE <<< (WO - 1)) - ONE;
  localparam logic signed [WX-1:0] VMIN = -(ONE <<< (WO - 1));

  logic                 out_valid_q, out_valid_d;
  logic [WO-1:0]        out_q, out_d;
  logic [IDW-1:0]       out_id_q, out_id_d;
  logic                 up_q, up_d;
  logic                 dn_q, dn_d;
  logic [IDW-1:0]       rr_q, rr_d;

  logic                 gnt_found, accept, xfer;
  logic [IDW-1:0]       gnt_idx, cand;
  logic [NREQ-1:0]      req_ready;
  logic [WI-1:0]        a_raw, b_raw;
  logic signed [WX-1:0] op_a, op_b, sum, rnd, red;
  logic [WO-1:0]        res;
  logic                 res_up, res_dn;

  // NOTE: every variable written in an always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(rr_q) + k) % NREQ);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    accept    = !out_valid_q || bus.out_ready;
    xfer      = accept && gnt_found && !rst;
    req_ready = '0;
    if (xfer) req_ready[gnt_idx] = 1'b1;
  end

  // Datapath works on the granted requester only; headroom in WX covers -(-min) and the rounding carry.
  always_comb begin
    a_raw = bus.req_ina[gnt_idx*WI +: WI];
    b_raw = bus.req_inb[gnt_idx*WI +: WI];
    op_a  = {{(WX-WI){a_raw[WI-1]}}, a_raw};
    op_b  = {{(WX-WI){b_raw[WI-1]}}, b_raw};
    sum   = bus.req_sub[gnt_idx] ? (op_a - op_b) : (op_a + op_b);
    rnd   = '0;
    if (ROUND != 0 && SHR > 0) rnd[RSH] = 1'b1;
    red    = ((sum + rnd) >>> SHR) <<< SHL;
    res_up = (red > VMAX);
    res_dn = (red < VMIN);
    res    = red[WO-1:0];
    if (ROOF != 0 && res_up) res = {1'b0, {(WO-1){1'b1}}};
    if (ROOF != 0 && res_dn) res = {1'b1, {(WO-1){1'b0}}};
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_id_d    = out_id_q;
    up_d        = up_q;
    dn_d        = dn_q;
    rr_d        = rr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_d       = res;
      out_id_d    = gnt_idx;
      up_d        = res_up;
      dn_d        = res_dn;
      rr_d        = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_id_q    <= '0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      rr_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_id_q    <= out_id_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
      rr_q        <= rr_d;
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out          = out_q;
  assign bus.out_id       = out_id_q;
  assign bus.out_upflow   = up_q;
  assign bus.out_downflow = dn_q;
endmodule

// File: tb/tb_fixedpoint_addsub_arbiter.sv
// Bench for the shared add/sub arbiter: four parameterisations share one stimulus stream;
// table vectors carry hand-computed results, a queue scoreboard tracks every result of the default DUT.
module tb_fixedpoint_addsub_arbiter;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  fixedpoint_addsub_arbiter_if #(.NREQ(NREQ))          ifa ();
  fixedpoint_addsub_arbiter_if #(.NREQ(NREQ))          ifb ();
  fixedpoint_addsub_arbiter_if #(.NREQ(NREQ), .WOF(4)) ifc ();
  fixedpoint_addsub_arbiter_if #(.NREQ(NREQ), .WOF(4)) ifd ();

  fixedpoint_addsub_arbiter #(.NREQ(NREQ))                      dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  fixedpoint_addsub_arbiter #(.NREQ(NREQ), .ROOF(0))            dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  fixedpoint_addsub_arbiter #(.NREQ(NREQ), .WOF(4), .ROUND(1))  dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));
  fixedpoint_addsub_arbiter #(.NREQ(NREQ), .WOF(4), .ROUND(0))  dut_d (.clk(clk), .rst(rst), .bus(ifd.slave));

  assign ifb.req_valid = ifa.req_valid; assign ifc.req_valid = ifa.req_valid; assign ifd.req_valid = ifa.req_valid;
  assign ifb.req_ina   = ifa.req_ina;   assign ifc.req_ina   = ifa.req_ina;   assign ifd.req_ina   = ifa.req_ina;
  assign ifb.req_inb   = ifa.req_inb;   assign ifc.req_inb   = ifa.req_inb;   assign ifd.req_inb   = ifa.req_inb;
  assign ifb.req_sub   = ifa.req_sub;   assign ifc.req_sub   = ifa.req_sub;   assign ifd.req_sub   = ifa.req_sub;
  assign ifb.out_ready = ifa.out_ready; assign ifc.out_ready = ifa.out_ready; assign ifd.out_ready = ifa.out_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard for the default DUT (WOI=WOF=8, saturate): the exact sum in 1/256 units is already the result scale.
  typedef struct {
    logic [1:0]  id;
    logic [15:0] o;
    logic        up;
    logic        dn;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_mon;

  function automatic exp_t model(input int id, input logic [15:0] a, input logic [15:0] b, input logic sub);
    exp_t   e;
    longint av = longint'($signed(a));
    longint bv = longint'($signed(b));
    longint r  = sub ? av - bv : av + bv;
    e.id = 2'(id);
    e.up = (r > 32767);
    e.dn = (r < -32768);
    e.o  = e.up ? 16'h7FFF : (e.dn ? 16'h8000 : 16'(r));
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (ifa.out_valid && ifa.out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_result", 32'(ifa.out_valid), 32'(0));
        end else begin
          e_mon = sb_q.pop_front();
          check("sb_id",   32'(ifa.out_id),       32'(e_mon.id));
          check("sb_out",  32'(ifa.out),          32'(e_mon.o));
          check("sb_up",   32'(ifa.out_upflow),   32'(e_mon.up));
          check("sb_dn",   32'(ifa.out_downflow), 32'(e_mon.dn));
        end
      end
      for (int i = 0; i < NREQ; i++)
        if (ifa.req_valid[i] && ifa.req_ready[i])
          sb_q.push_back(model(i, ifa.req_ina[i*16 +: 16], ifa.req_inb[i*16 +: 16], ifa.req_sub[i]));
    end
  end

  // Flag bit order in the vector records: bit0 = dut_a, bit1 = dut_b, bit2 = dut_c, bit3 = dut_d.
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    int          req;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [11:0] ec;
    logic [11:0] ed;
    logic [3:0]  up;
    logic [3:0]  dn;
  } vec_t;

  vec_t vecs[8];

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic s);
    ifa.req_valid[i]         = 1'b1;
    ifa.req_ina[i*16 +: 16]  = a;
    ifa.req_inb[i*16 +: 16]  = b;
    ifa.req_sub[i]           = s;
  endtask

  initial begin
    vecs[0] = '{16'h0180, 16'h0240, 1'b0, 2, 16'h03C0, 16'h03C0, 12'h03C, 12'h03C, 4'b0000, 4'b0000};
    vecs[1] = '{16'h0100, 16'h0300, 1'b1, 0, 16'hFE00, 16'hFE00, 12'hFE0, 12'hFE0, 4'b0000, 4'b0000};
    vecs[2] = '{16'h6400, 16'h6400, 1'b0, 1, 16'h7FFF, 16'hC800, 12'h7FF, 12'h7FF, 4'b1111, 4'b0000};
    vecs[3] = '{16'h0008, 16'h0000, 1'b0, 3, 16'h0008, 16'h0008, 12'h001, 12'h000, 4'b0000, 4'b0000};
    vecs[4] = '{16'hFFF8, 16'h0000, 1'b0, 2, 16'hFFF8, 16'hFFF8, 12'h000, 12'hFFF, 4'b0000, 4'b0000};
    vecs[5] = '{16'h8000, 16'h0100, 1'b1, 0, 16'h8000, 16'h7F00, 12'h800, 12'h800, 4'b0000, 4'b1111};
    vecs[6] = '{16'h0000, 16'h8000, 1'b1, 1, 16'h7FFF, 16'h8000, 12'h7FF, 12'h7FF, 4'b1111, 4'b0000};
    vecs[7] = '{16'h7FF8, 16'h0000, 1'b0, 3, 16'h7FF8, 16'h7FF8, 12'h7FF, 12'h7FF, 4'b0100, 4'b0000};

    ifa.req_valid = '0;
    ifa.req_ina   = '0;
    ifa.req_inb   = '0;
    ifa.req_sub   = '0;
    ifa.out_ready = 1'b1;
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", 32'({ifd.out_valid, ifc.out_valid, ifb.out_valid, ifa.out_valid}), 32'(0));
    check("rst_out",       32'(ifa.out),    32'(0));
    check("rst_out_id",    32'(ifa.out_id), 32'(0));
    check("rst_flags",     32'({ifa.out_upflow, ifa.out_downflow}), 32'(0));
    ifa.req_valid = 4'hF;
    #1 check("rst_req_ready", 32'(ifa.req_ready), 32'(0));
    ifa.req_valid = '0;
    @(posedge clk); #1 rst = 1'b0;

    // Round-robin under full load: grants 0,1,2,3,0,1,2,3 with fresh operands after each grant.
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) set_req(i, 16'($urandom), 16'($urandom), 1'($urandom));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_ready", 32'(ifa.req_ready), 32'(1) << (k % NREQ));
      @(posedge clk); #1;
      set_req(k % NREQ, 16'($urandom), 16'($urandom), 1'($urandom));
    end
    ifa.req_valid = '0;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      int w;
      @(posedge clk); #1;
      set_req(vecs[v].req, vecs[v].a, vecs[v].b, vecs[v].sub);
      w = 0;
      forever begin
        @(negedge clk);
        if (ifa.req_ready[vecs[v].req]) break;
        w++;
        if (w >= 10) begin
          check("grant_timeout", 32'(0), 32'(1));
          break;
        end
      end
      @(posedge clk); #1;
      ifa.req_valid = '0;
      @(negedge clk);
      check("vec_valid", 32'({ifd.out_valid, ifc.out_valid, ifb.out_valid, ifa.out_valid}), 32'(4'hF));
      check("vec_id",    32'(ifa.out_id), 32'(vecs[v].req));
      check("vec_out_a", 32'(ifa.out), 32'(vecs[v].ea));
      check("vec_out_b", 32'(ifb.out), 32'(vecs[v].eb));
      check("vec_out_c", 32'(ifc.out), 32'(vecs[v].ec));
      check("vec_out_d", 32'(ifd.out), 32'(vecs[v].ed));
      check("vec_up", 32'({ifd.out_upflow, ifc.out_upflow, ifb.out_upflow, ifa.out_upflow}), 32'(vecs[v].up));
      check("vec_dn", 32'({ifd.out_downflow, ifc.out_downflow, ifb.out_downflow, ifa.out_downflow}), 32'(vecs[v].dn));
    end

    // Backpressure: hold a result from requester 1 while every lane keeps requesting.
    @(posedge clk); #1;
    ifa.out_ready = 1'b0;
    set_req(1, 16'h0180, 16'h0240, 1'b0);
    @(posedge clk); #1;
    set_req(0, 16'h0100, 16'h0100, 1'b0);
    set_req(1, 16'h0200, 16'h0100, 1'b1);
    set_req(2, 16'h0300, 16'h0100, 1'b0);
    set_req(3, 16'h0400, 16'h0100, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(ifa.out_valid), 32'(1));
      check("hold_out",   32'(ifa.out),       32'(16'h03C0));
      check("hold_id",    32'(ifa.out_id),    32'(1));
      check("hold_ready", 32'(ifa.req_ready), 32'(0));
    end
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(ifa.out_valid), 32'(0));
    check("async_rst_out",   32'(ifa.out),       32'(0));
    check("async_rst_ready", 32'(ifa.req_ready), 32'(0));
    @(negedge clk);
    @(posedge clk); #1;
    rst           = 1'b0;
    ifa.out_ready = 1'b1;
    @(negedge clk);
    check("first_grant_after_rst", 32'(ifa.req_ready), 32'(4'b0001));
    @(posedge clk); #1;
    ifa.req_valid = '0;
    @(negedge clk);
    check("post_rst_id", 32'(ifa.out_id), 32'(0));
    check("post_rst_out", 32'(ifa.out), 32'(16'h0200));
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/fixedpoint_addsub_arbiter.md
Name: fixedpoint_addsub_arbiter

Overview:
- Shares one fixed-point add/subtract datapath among NREQ requesters, using round-robin arbitration.
- Each requester presents operands a, b and an add/sub select over a valid/ready handshake.
- Results come from a single registered output slot, tagged with the requester id and carrying overflow flags.
- The block sits between filter/accumulator lanes and the arithmetic core. Lanes do not each instantiate their own adder.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WII, 8, integer bits of both operands (two's complement, sign included).
- WIF, 8, fractional bits of both operands.
- WOI, 8, integer bits of the result.
- WOF, 8, fractional bits of the result.
- ROOF, 1, 1 = saturate on overflow, 0 = wrap (keep low bits).
- ROUND, 1, 1 = round half up on fraction reduction, 0 = truncate toward minus infinity.
- IDW, $clog2(NREQ) (min 1), width of the requester id.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_ina  in  NREQ*(WII+WIF)  operand a; requester i uses bits [i*(WII+WIF) +: WII+WIF].
- req_inb  in  NREQ*(WII+WIF)  operand b; same packing as req_ina.
- req_sub  in  NREQ  0 = a+b, 1 = a-b.
- out_valid  out  1  result slot holds a valid result.
- out_ready  in  1  downstream accepts the result.
- out  out  WOI+WOF  result.
- out_id  out  IDW  index of the requester that produced the result.
- out_upflow  out  1  result exceeded the positive range (saturated or wrapped).
- out_downflow  out  1  result exceeded the negative range.

Behaviour:
- Reset (asynchronous, immediate): out_valid=0, out=0, out_id=0, out_upflow=0, out_downflow=0, rr pointer=0.
  - req_ready is combinational; it evaluates to 0 while rst is high.
  - Any in-flight or unconsumed result is discarded.
- Slot accept condition: accept = !out_valid || out_ready.
- Grant:
  - Combinational, when accept=1.
  - grant = first i with req_valid[i]=1, scanning from the rr pointer upward modulo NREQ.
  - req_ready[grant]=1; all other bits are 0.
  - If accept=0 or no request is valid, all req_ready bits are 0.
- Transfer: occurs on an edge where req_valid[i] && req_ready[i]. On that edge:
  - out, out_id, out_upflow and out_downflow load the computed result.
  - out_valid becomes 1.
  - rr pointer becomes (grant+1) mod NREQ.
- Pointer hold: the rr pointer does not change on cycles with no transfer.
- Drain: on an edge with out_valid && out_ready and no transfer, out_valid becomes 0. Data outputs hold their last values.
- Simultaneous drain and transfer: the slot is overwritten with the new result and out_valid stays 1. This gives one result per cycle of sustained throughput.
- Latency: 1 cycle from request transfer to out_valid.
- Backpressure: while out_valid=1 and out_ready=0, all outputs hold stable and all req_ready bits are 0.
- Fairness: with all NREQ valid and out_ready=1, grant order is 0,1,...,NREQ-1,0,...
  - No requester waits more than NREQ-1 grants once its valid is asserted.
- Arithmetic:
  - Compute exact r = a ± b in (WII+2).(WIF) two's complement. This covers the -(-2^(WII-1)) case.
  - Fraction reduction applies only if WOF < WIF:
    - ROUND=1: add 2^(WIF-WOF-1) before truncating.
    - ROUND=0: drop the low bits (floor).
  - Fraction extension applies if WOF >= WIF: zero-extend the fraction.
  - Range check: after reduction, compare against [-2^(WOI-1), 2^(WOI-1)-2^-WOF].
    - Above the range: out_upflow=1.
    - Below the range: out_downflow=1.
  - Out-of-range result:
    - ROOF=1: output the saturated max 0111..1 or min 1000..0.
    - ROOF=0: output the low WOI+WOF bits.
  - The flags are set in both ROOF modes.
  - Rounding carry into the integer part can itself cause upflow and is handled by the same check.
- Requester rules:
  - A requester must hold valid, operands and sub stable until ready.
  - Operand changes while not granted are legal; they are sampled only at transfer.

Test Plan:
- Basic add (defaults, NREQ=4): req 2 with a=0x0180 (1.5), b=0x0240 (2.25), sub=0 -> next cycle out_valid=1, out=0x03C0, out_id=2, flags 0.
- Subtract: req 0 with a=0x0100, b=0x0300, sub=1 -> out=0xFE00 (-2.0), flags 0.
- Saturation, ROOF=1: a=0x6400, b=0x6400, add -> out=0x7FFF, out_upflow=1. Same with ROOF=0 -> out=0xC800, out_upflow=1.
- Rounding (WOF=4, ROUND=1): a=0x0008, b=0x0000 -> out=0x001. With ROUND=0 -> out=0x000. Also a=0xFFF8 (-1/32), ROUND=1 -> out=0x000.
- Arbitration and throughput: all four valid, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3 on consecutive cycles, exactly one req_ready per cycle.
- Backpressure and reset: out_ready=0 with a held result -> out stable and req_ready=0 for 5 cycles. Then assert rst mid-hold -> out_valid=0 immediately, and the first grant after reset goes to requester 0.
